// File: rtl/sobel_thr_ctrl.sv
// sobel_thr_ctrl: per-frame adaptive threshold controller for the 3x3 Sobel filter.
// Counts edge pixels (0xFF, qualified by sobel_ready and enable) over a frame,
// evaluates the count at frame end and applies the resulting threshold only at the
// next frame start, so the filter never sees a threshold change mid-frame.
// Ports:
//   clk, rst            pixel clock, synchronous active-high reset
//   enable              pixel-clock enable (gates counting only)
//   vsync               frame sync: falling edge = frame start, rising edge = frame end
//   sobel_ready/pixel   filter output valid / value (0x00 or 0xFF)
//   auto_mode           1 = adaptive, 0 = manual pass-through of manual_thr
//   manual_thr          manual threshold (clamped)
//   threshold           threshold driven to the filter
//   edge_count          latched edge count of the last completed frame
//   count_valid         one-cycle pulse when edge_count updates
//   settling            settle counter nonzero
module sobel_thr_ctrl #(
  parameter int unsigned IMG_WIDTH     = 320,
  parameter int unsigned IMG_HEIGHT    = 240,
  parameter int unsigned THR_INIT      = 64,
  parameter int unsigned THR_MIN       = 8,
  parameter int unsigned THR_MAX       = 240,
  parameter int unsigned STEP          = 4,
  parameter int unsigned TARGET_LO     = 2000,
  parameter int unsigned TARGET_HI     = 6000,
  parameter int unsigned SETTLE_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        vsync,
  input  logic        sobel_ready,
  input  logic [7:0]  sobel_pixel,
  input  logic        auto_mode,
  input  logic [7:0]  manual_thr,
  output logic [7:0]  threshold,
  output logic [16:0] edge_count,
  output logic        count_valid,
  output logic        settling
);

  localparam int unsigned THR_W = 8;
  localparam int unsigned CNT_W = 17;
  // Always at least one bit, even when SETTLE_FRAMES is 0.
  localparam int unsigned SET_W = $clog2(SETTLE_FRAMES + 2);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_MEASURE = 2'd1;
  localparam logic [1:0] S_EVAL    = 2'd2;
  localparam logic [1:0] S_HOLD    = 2'd3;

  // A full frame must fit the saturating counter.
  if ((IMG_WIDTH * IMG_HEIGHT) > ((1 << CNT_W) - 1)) begin : g_size_err
    $error("sobel_thr_ctrl: frame size exceeds edge counter range");
  end

  function automatic logic [THR_W-1:0] clamp_thr(input int unsigned v);
    if (v < THR_MIN)      return THR_W'(THR_MIN);
    else if (v > THR_MAX) return THR_W'(THR_MAX);
    else                  return THR_W'(v);
  endfunction

  localparam logic [THR_W-1:0] THR_RST = clamp_thr(THR_INIT);

  logic [1:0]       state_q, state_d;
  logic             vsync_prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] edge_q, edge_d;
  logic             cv_q, cv_d;
  logic [THR_W-1:0] thr_q, thr_d;
  logic [THR_W-1:0] nthr_q, nthr_d;
  logic [SET_W-1:0] set_q, set_d;
  logic             settling_q;

  logic             frame_start_c, frame_end_c, pix_hit_c;
  logic [CNT_W-1:0] cnt_hit_c;
  logic [8:0]       up_c;
  logic signed [9:0] dn_c;
  logic [THR_W-1:0] up_thr_c, dn_thr_c, cand_c;

  assign frame_start_c = vsync_prev_q & ~vsync;
  assign frame_end_c   = ~vsync_prev_q & vsync;
  assign pix_hit_c     = enable & sobel_ready & (sobel_pixel == 8'hFF);

  // Counter value including this cycle's qualifying pixel, saturating.
  assign cnt_hit_c = (pix_hit_c && (cnt_q != CNT_MAX)) ? cnt_q + CNT_W'(1) : cnt_q;

  // Step candidates computed wide enough that they never wrap.
  assign up_c     = {1'b0, thr_q} + 9'(STEP);
  assign dn_c     = $signed({2'b00, thr_q}) - $signed(10'(STEP));
  assign up_thr_c = (up_c > 9'(THR_MAX)) ? THR_W'(THR_MAX) : up_c[7:0];
  assign dn_thr_c = (dn_c < $signed(10'(THR_MIN))) ? THR_W'(THR_MIN) : dn_c[7:0];

  // Next-state and datapath decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    edge_d  = edge_q;
    cv_d    = 1'b0;
    thr_d   = thr_q;
    nthr_d  = nthr_q;
    set_d   = set_q;
    cand_c  = thr_q;
    case (state_q)
      S_IDLE: begin
        if (frame_start_c) begin
          cnt_d   = '0;
          state_d = S_MEASURE;
        end
      end
      S_MEASURE: begin
        if (frame_end_c) begin
          edge_d  = cnt_hit_c;
          cnt_d   = cnt_hit_c;
          cv_d    = 1'b1;
          state_d = S_EVAL;
        end else if (frame_start_c) begin
          // Frame restarted without an end: discard the partial count.
          cnt_d = '0;
        end else begin
          cnt_d = cnt_hit_c;
        end
      end
      S_EVAL: begin
        state_d = S_HOLD;
        if (!auto_mode) begin
          nthr_d = clamp_thr(32'(manual_thr));
          set_d  = '0;
        end else if (set_q != '0) begin
          nthr_d = thr_q;
          set_d  = set_q - SET_W'(1);
        end else begin
          if (edge_q > CNT_W'(TARGET_HI))      cand_c = up_thr_c;
          else if (edge_q < CNT_W'(TARGET_LO)) cand_c = dn_thr_c;
          else                                 cand_c = thr_q;
          nthr_d = cand_c;
          if (cand_c != thr_q) set_d = SET_W'(SETTLE_FRAMES);
        end
      end
      S_HOLD: begin
        if (frame_start_c) begin
          thr_d   = nthr_q;
          cnt_d   = '0;
          state_d = S_MEASURE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; vsync_prev tracks vsync even in reset.
  always_ff @(posedge clk) begin
    vsync_prev_q <= vsync;
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      edge_q     <= '0;
      cv_q       <= 1'b0;
      thr_q      <= THR_RST;
      nthr_q     <= THR_RST;
      set_q      <= '0;
      settling_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      edge_q     <= edge_d;
      cv_q       <= cv_d;
      thr_q      <= thr_d;
      nthr_q     <= nthr_d;
      set_q      <= set_d;
      settling_q <= (set_d != '0);
    end
  end

  assign threshold   = thr_q;
  assign edge_count  = edge_q;
  assign count_valid = cv_q;
  assign settling    = settling_q;

endmodule

// File: tb/tb_sobel_thr_ctrl.sv
// tb_sobel_thr_ctrl: randomized frames driven into sobel_thr_ctrl; a frame-level
// reference model queues expected evaluation results and threshold updates, and an
// independent monitor checks them as the DUT presents count_valid / threshold changes.
module tb_sobel_thr_ctrl;

  localparam int THR_INIT = 64;
  localparam int THR_MIN  = 8;
  localparam int THR_MAX  = 240;
  localparam int STEP     = 4;
  localparam int T_LO     = 20;
  localparam int T_HI     = 60;
  localparam int SETTLE   = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        vsync;
  logic        sobel_ready;
  logic [7:0]  sobel_pixel;
  logic        auto_mode;
  logic [7:0]  manual_thr;
  logic [7:0]  threshold;
  logic [16:0] edge_count;
  logic        count_valid;
  logic        settling;

  always #5 clk = ~clk;

  sobel_thr_ctrl #(
    .IMG_WIDTH(320), .IMG_HEIGHT(240), .THR_INIT(THR_INIT), .THR_MIN(THR_MIN),
    .THR_MAX(THR_MAX), .STEP(STEP), .TARGET_LO(T_LO), .TARGET_HI(T_HI),
    .SETTLE_FRAMES(SETTLE)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .vsync(vsync),
    .sobel_ready(sobel_ready), .sobel_pixel(sobel_pixel),
    .auto_mode(auto_mode), .manual_thr(manual_thr),
    .threshold(threshold), .edge_count(edge_count),
    .count_valid(count_valid), .settling(settling)
  );

  typedef struct {
    int cnt;
    int thr;
    int settling;
  } ev_t;

  ev_t ev_q[$];
  int  thr_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;

  // Reference model state: 0 = waiting for first frame, 1 = measuring, 2 = evaluated.
  int  m_phase, m_cnt, m_thr, m_next, m_settle;
  bit  m_vs;

  function automatic int clampi(int v);
    if (v < THR_MIN) return THR_MIN;
    if (v > THR_MAX) return THR_MAX;
    return v;
  endfunction

  task automatic check(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame-end decision: what threshold the next frame should use.
  function automatic void model_eval();
    ev_t e;
    e.cnt = m_cnt; e.thr = m_thr; e.settling = (m_settle != 0) ? 1 : 0;
    ev_q.push_back(e);
    if (!auto_mode) begin
      m_next = clampi(int'(manual_thr));
      m_settle = 0;
    end else if (m_settle != 0) begin
      m_next = m_thr;
      m_settle--;
    end else begin
      if (m_cnt > T_HI)      m_next = (m_thr + STEP > THR_MAX) ? THR_MAX : m_thr + STEP;
      else if (m_cnt < T_LO) m_next = (m_thr - STEP < THR_MIN) ? THR_MIN : m_thr - STEP;
      else                   m_next = m_thr;
      if (m_next != m_thr) m_settle = SETTLE;
    end
    m_phase = 2;
  endfunction

  // One pixel clock: drive random pixel data with given vsync; p = % chance of 0xFF.
  task automatic step(bit vs, int p);
    logic [7:0] px;
    logic e, r;
    bit q, fs, fe;
    @(negedge clk);
    e  = ($urandom % 8) != 0;
    r  = ($urandom % 8) != 0;
    px = (($urandom % 100) < p) ? 8'hFF : 8'($urandom % 255);
    enable = e; sobel_ready = r; sobel_pixel = px; vsync = vs;
    q  = e && r && (px == 8'hFF);
    fs = m_vs && !vs;
    fe = !m_vs && vs;
    m_vs = vs;
    case (m_phase)
      0: if (fs) begin m_phase = 1; m_cnt = 0; end
      1: begin
        if (fs) m_cnt = 0;
        else begin
          if (q) m_cnt++;
          if (fe) model_eval();
        end
      end
      default: if (fs) begin
        if (m_next != m_thr) thr_q.push_back(m_next);
        m_thr = m_next; m_cnt = 0; m_phase = 1;
      end
    endcase
  endtask

  // kind: 0 = high count, 1 = low count, 2 = in band.
  task automatic frame(int kind, bit am, int man);
    int len, p;
    auto_mode = am;
    manual_thr = 8'(man);
    case (kind)
      0:       begin len = 130; p = 90; end
      1:       begin len = 30;  p = 30; end
      default: begin len = 60;  p = 70; end
    endcase
    for (int i = 0; i < len; i++) step(1'b0, p);
    step(1'b1, p);
    for (int i = 0; i < 4; i++) step(1'b1, p);
  endtask

  task automatic do_reset(bit vs);
    @(negedge clk);
    rst = 1'b1; vsync = vs;
    repeat (2) @(negedge clk);
    m_vs = vs; m_phase = 0; m_cnt = 0;
    m_thr = clampi(THR_INIT); m_next = m_thr; m_settle = 0;
    ev_q.delete(); thr_q.delete();
    check("rst_threshold", int'(threshold), THR_INIT);
    check("rst_edge_count", int'(edge_count), 0);
    check("rst_count_valid", int'(count_valid), 0);
    check("rst_settling", int'(settling), 0);
    rst = 1'b0;
  endtask

  // Monitor: evaluation results on count_valid, threshold updates on change.
  initial begin
    bit v_last;
    bit fs;
    int thr_last;
    ev_t e;
    v_last = 1'b0;
    thr_last = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        v_last = vsync;
        thr_last = int'(threshold);
        continue;
      end
      fs = v_last && !vsync;
      v_last = vsync;
      if (count_valid) begin
        if (ev_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL cv_unexpected: got count_valid=1 edge_count=%0d, expected no pulse (t=%0t)",
                   edge_count, $time);
        end else begin
          e = ev_q.pop_front();
          check("edge_count", int'(edge_count), e.cnt);
          check("thr_at_eval", int'(threshold), e.thr);
          check("settling_at_eval", int'(settling), e.settling);
        end
      end
      if (int'(threshold) != thr_last) begin
        check("thr_change_at_frame_start", int'(fs), 1);
        if (thr_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL thr_unexpected: got threshold=%0d, expected %0d (t=%0t)",
                   threshold, thr_last, $time);
        end else begin
          check("thr_value", int'(threshold), thr_q.pop_front());
        end
        thr_last = int'(threshold);
      end
    end
  end

  initial begin
    rst = 1'b1; enable = 1'b0; vsync = 1'b0; sobel_ready = 1'b0;
    sobel_pixel = 8'h00; auto_mode = 1'b1; manual_thr = 8'd0;
    do_reset(1'b0);

    // Partial first frame, then a frame_end in IDLE that must be ignored.
    for (int i = 0; i < 40; i++) step(1'b0, 80);
    for (int i = 0; i < 5; i++) step(1'b1, 80);

    // High counts: step up, held while settling, then step again.
    for (int i = 0; i < 5; i++) frame(0, 1'b1, 0);
    check("thr_after_high_frames", int'(threshold), 72);

    // Lower clamp: 10 stepping down must land on THR_MIN and stay there.
    frame(2, 1'b0, 10);
    frame(1, 1'b1, 0);
    check("thr_min_plus2", int'(threshold), 10);
    for (int i = 0; i < 5; i++) frame(1, 1'b1, 0);
    check("thr_lower_clamp", int'(threshold), THR_MIN);

    // Manual mode: clamp above, pass-through in range regardless of count.
    frame(2, 1'b0, 250);
    frame(0, 1'b0, 30);
    check("thr_manual_clamp", int'(threshold), THR_MAX);
    frame(1, 1'b0, 30);
    check("thr_manual_30", int'(threshold), 30);

    // Upper clamp from 238.
    frame(2, 1'b0, 238);
    for (int i = 0; i < 5; i++) frame(0, 1'b1, 0);
    check("thr_upper_clamp", int'(threshold), THR_MAX);

    // Random frames, modes and manual values.
    for (int i = 0; i < 30; i++)
      frame(int'($urandom % 3), 1'b1 ^ (($urandom % 4) == 0), int'($urandom % 256));

    // Reset mid-measure discards the frame; next frame_end ignored until a start.
    frame(0, 1'b0, 30);
    frame(0, 1'b0, 30);
    for (int i = 0; i < 60; i++) step(1'b0, 90);
    do_reset(1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, 90);
    for (int i = 0; i < 5; i++) step(1'b1, 90);
    check("thr_after_reset_idle", int'(threshold), THR_INIT);
    for (int i = 0; i < 3; i++) frame(0, 1'b1, 0);

    repeat (10) @(negedge clk);
    check("ev_queue_drained", ev_q.size(), 0);
    check("thr_queue_drained", thr_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
